fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction fetch stage for the 16-bit WISC CPU. Owns the architectural PC and issues requests to a variable-latency instruction memory. Delivers one instruction per cycle with its PC and PC+2 into the IF/ID boundary consumed by decode. Honours stall, branch redirect and HLT, with a one-entry skid buffer so memory responses are never lost.

## Interface
- RESET_PC, 16'h0000, PC fetched first after reset
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  decode cannot accept; hold if_* outputs
- redirect  in  1  branch/flush from downstream; highest priority
- redirect_pc  in  16  target PC when redirect=1
- mem_req  out  1  instruction read request; held until mem_ack
- mem_addr  out  16  byte address of request; stable while mem_req=1
- mem_ack  in  1  response valid; only meaningful when mem_req=1
- mem_rdata  in  16  instruction word, valid with mem_ack
- if_valid  out  1  if_instr/if_pc/if_pc_next hold a live instruction
- if_instr  out  16  fetched instruction
- if_pc  out  16  address of if_instr
- if_pc_next  out  16  if_pc + 2, modulo 2^16
- halted  out  1  fetch stopped on HLT

## Operation
- States: REQ (request outstanding or issuable), DRAIN (discarding a squashed response), HALT.
- Response handshake: a transfer occurs in any cycle with mem_req=1 and mem_ack=1, including the first request cycle (zero-wait memory). mem_req never drops and mem_addr never changes before the ack.
- Accepted response (state REQ, no redirect that cycle): pc <= pc+2. The word goes to the output register if it is free (if_valid=0 or stall=0), otherwise to the skid buffer.
- Output register advance: when stall=0, the output loads the skid entry if one is held, else the new response, else clears if_valid.
- Request issue: mem_req is asserted in REQ whenever the skid is empty. While the skid is full, no new request is issued. An in-flight request still completes, because the skid always has room for it.
- Redirect (any state): if_valid and the skid are cleared and pc <= redirect_pc.
  - Request outstanding without ack this cycle: go to DRAIN. Keep the old mem_addr until ack, discard the data, then go to REQ at redirect_pc.
  - Ack in the same cycle: discard the data; the next cycle requests redirect_pc.
  - Redirect overrides stall.
- PC arithmetic: 16-bit unsigned, wraps 16'hFFFE -> 16'h0000. Bit 0 is passed through unmodified.
- Reset mid-request: all state is cleared immediately. Any response arriving after reset is ignored unless mem_req=1.

## Timing
- Reset values: mem_req=0, mem_addr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_pc_next=0, halted=0, state=REQ, skid empty.
- First cycle after rst_n rises: mem_req=1 with mem_addr=RESET_PC.
- Latency from ack to output: one cycle (ack at edge N gives if_valid=1 after edge N+1).
- Throughput: with a zero-wait memory and stall=0, one instruction per cycle.
- Redirect at cycle N with no outstanding request: mem_req with redirect_pc at N+1; earliest if_valid at N+2 for a zero-wait memory.
- halted asserts on the same edge that loads the HLT word into the output register.

## Configuration
- FETCH_HLT_DETECT_EN defined:
  - An accepted word with [15:12]==4'hF enters HALT. No further requests are issued; an outstanding request cannot exist, since the HLT word was the ack.
  - The HLT word is still presented on if_*, and halted=1.
  - Only redirect leaves HALT; this covers a HLT in a mispredicted shadow. Leaving HALT clears halted.
- FETCH_HLT_DETECT_EN undefined: HLT is fetched like any other word, fetch continues to pc+2, and halted is tied 0.

## Test plan
- Reset then zero-wait memory returning 16'h1000+addr, stall=0 -> mem_addr sequence 0,2,4,6 on consecutive cycles; if_pc/if_instr follow one cycle later; if_pc_next=if_pc+2.
- 3-cycle ack latency, stall asserted for 4 cycles while if_valid=1 -> mem_addr held stable through each wait. No word is lost or duplicated: the skid fills, requests pause, and the order resumes exactly after stall drops.
- Redirect to 16'h0040 while the request to 16'h0006 waits 2 cycles -> DRAIN. The 0x0006 data is never shown; the next request is 0x0040 and if_pc=0x0040 is the first valid output.
- Redirect coinciding with ack -> the acked word is discarded and the next cycle's mem_addr equals redirect_pc.
- Word 16'hF000 at 0x000A with FETCH_HLT_DETECT_EN -> halted=1, if_instr=16'hF000, mem_req stays 0 for 20 cycles; a redirect to 0x0000 restarts fetch with halted=0. Without the macro, mem_addr 0x000C follows.
- Start at RESET_PC=16'hFFFE -> if_pc_next=16'h0000 and the next mem_addr is 16'h0000. Asserting rst_n=0 mid-wait drops mem_req asynchronously.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage -- instruction fetch for the 16-bit WISC CPU.
// Owns the architectural PC and keeps one read outstanding to a
// variable-latency instruction memory. Each word goes to the IF/ID output
// register, or to a one-entry skid buffer while decode stalls, so no
// response is ever dropped. A redirect flushes the stage. If the redirect
// arrives while a read is still outstanding, the stage first drains that
// read and throws its data away.
// Optional feature: define FETCH_HLT_DETECT_EN to stop fetching after a
// HLT word (opcode 4'hF). Left undefined, HLT is fetched like any other
// word and halted stays 0.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic [15:0] if_pc_next,
  output logic        halted
);

`ifdef FETCH_HLT_DETECT_EN
  localparam logic HLT_EN = 1'b1;
`else
  localparam logic HLT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  // Sequential PC step; 16-bit add wraps 16'hFFFE to 16'h0000, bit 0 untouched.
  function automatic logic [15:0] pc_inc(input logic [15:0] pc);
    return pc + 16'h0002;
  endfunction

  // HLT opcode match, only meaningful when detection is built in.
  function automatic logic is_hlt(input logic [3:0] opcode);
    return HLT_EN & (opcode == 4'hF);
  endfunction

  state_t      state_r, state_s;
  logic [15:0] pc_r, pc_s;
  logic        mem_req_r, mem_req_s;
  logic [15:0] mem_addr_r, mem_addr_s;
  logic        skid_valid_r, skid_valid_s;
  logic [15:0] skid_instr_r, skid_instr_s;
  logic [15:0] skid_pc_r, skid_pc_s;
  logic        if_valid_r, if_valid_s;
  logic [15:0] if_instr_r, if_instr_s;
  logic [15:0] if_pc_r, if_pc_s;
  logic [15:0] if_pc_next_r, if_pc_next_s;
  logic        halted_r, halted_s;
  logic        ack_s, accept_s, load_s;
  logic [15:0] load_instr_s, load_pc_s;

  // Next state, request control, skid buffer and output register selection.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    mem_req_s    = mem_req_r;
    mem_addr_s   = mem_addr_r;
    skid_valid_s = skid_valid_r;
    skid_instr_s = skid_instr_r;
    skid_pc_s    = skid_pc_r;
    if_valid_s   = if_valid_r;
    if_instr_s   = if_instr_r;
    if_pc_s      = if_pc_r;
    if_pc_next_s = if_pc_next_r;
    halted_s     = halted_r;
    load_s       = 1'b0;
    load_instr_s = 16'h0000;
    load_pc_s    = 16'h0000;
    ack_s        = mem_req_r & mem_ack;
    accept_s     = ack_s & (state_r == ST_REQ) & ~redirect;

    if (redirect) begin
      // Flush wins over stall; an un-acked read must be drained first.
      if_valid_s   = 1'b0;
      skid_valid_s = 1'b0;
      halted_s     = 1'b0;
      pc_s         = redirect_pc;
      if (mem_req_r && !mem_ack) begin
        state_s    = ST_DRAIN;
        mem_req_s  = 1'b1;
        mem_addr_s = mem_addr_r;
      end else begin
        state_s    = ST_REQ;
        mem_req_s  = 1'b1;
        mem_addr_s = redirect_pc;
      end
    end else begin
      // Output register prefers the older skid entry over a fresh response.
      if (!stall) begin
        if (skid_valid_r) begin
          load_s       = 1'b1;
          load_instr_s = skid_instr_r;
          load_pc_s    = skid_pc_r;
          skid_valid_s = 1'b0;
        end else if (accept_s) begin
          load_s       = 1'b1;
          load_instr_s = mem_rdata;
          load_pc_s    = mem_addr_r;
        end else begin
          if_valid_s = 1'b0;
        end
      end else if (accept_s && !if_valid_r) begin
        load_s       = 1'b1;
        load_instr_s = mem_rdata;
        load_pc_s    = mem_addr_r;
      end else if (accept_s) begin
        skid_valid_s = 1'b1;
        skid_instr_s = mem_rdata;
        skid_pc_s    = mem_addr_r;
      end else begin
        if_valid_s = if_valid_r;
      end

      if (load_s) begin
        if_valid_s   = 1'b1;
        if_instr_s   = load_instr_s;
        if_pc_s      = load_pc_s;
        if_pc_next_s = pc_inc(load_pc_s);
        halted_s     = halted_r | is_hlt(load_instr_s[15:12]);
      end else begin
        halted_s = halted_r;
      end

      case (state_r)
        ST_REQ: begin
          if (accept_s) begin
            pc_s = pc_inc(pc_r);
          end else begin
            pc_s = pc_r;
          end
          if (accept_s && is_hlt(mem_rdata[15:12])) begin
            state_s    = ST_HALT;
            mem_req_s  = 1'b0;
            mem_addr_s = mem_addr_r;
          end else begin
            // A full skid pauses requests; an un-acked read keeps pc_s == mem_addr_r.
            state_s    = ST_REQ;
            mem_req_s  = ~skid_valid_s;
            mem_addr_s = pc_s;
          end
        end
        ST_DRAIN: begin
          if (ack_s) begin
            state_s    = ST_REQ;
            mem_req_s  = 1'b1;
            mem_addr_s = pc_r;
          end else begin
            state_s    = ST_DRAIN;
            mem_req_s  = 1'b1;
            mem_addr_s = mem_addr_r;
          end
        end
        ST_HALT: begin
          state_s   = ST_HALT;
          mem_req_s = 1'b0;
        end
        default: begin
          state_s    = ST_REQ;
          mem_req_s  = 1'b0;
          mem_addr_s = pc_r;
        end
      endcase
    end
  end

  // State and output registers; reset drops mem_req and clears everything at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_REQ;
      pc_r         <= RESET_PC;
      mem_req_r    <= 1'b0;
      mem_addr_r   <= RESET_PC;
      skid_valid_r <= 1'b0;
      skid_instr_r <= 16'h0000;
      skid_pc_r    <= 16'h0000;
      if_valid_r   <= 1'b0;
      if_instr_r   <= 16'h0000;
      if_pc_r      <= 16'h0000;
      if_pc_next_r <= 16'h0000;
      halted_r     <= 1'b0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      mem_req_r    <= mem_req_s;
      mem_addr_r   <= mem_addr_s;
      skid_valid_r <= skid_valid_s;
      skid_instr_r <= skid_instr_s;
      skid_pc_r    <= skid_pc_s;
      if_valid_r   <= if_valid_s;
      if_instr_r   <= if_instr_s;
      if_pc_r      <= if_pc_s;
      if_pc_next_r <= if_pc_next_s;
      halted_r     <= halted_s;
    end
  end

  assign mem_req    = mem_req_r;
  assign mem_addr   = mem_addr_r;
  assign if_valid   = if_valid_r;
  assign if_instr   = if_instr_r;
  assign if_pc      = if_pc_r;
  assign if_pc_next = if_pc_next_r;
  assign halted     = halted_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. A behavioural memory answers each
// request after `lat` wait cycles with 16'h1000+addr. Every word the memory
// hands over is pushed to a scoreboard unless that response is squashed.
// Each word decode accepts (if_valid & !stall) is popped and compared.
// Covers the optional FETCH_HLT_DETECT_EN build as well as the default build.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic [15:0] if_pc_next;
  logic        halted;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          pops     = 0;
  int          lat      = 0;
  int          cnt      = 0;
  bit          drain    = 1'b0;
  bit          prev_req = 1'b0;
  bit          prev_fire = 1'b0;
  logic [15:0] prev_addr = 16'h0000;
  bit          hlt_en   = 1'b0;
  logic [31:0] sb_q[$];

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_next  (if_pc_next),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (hlt_en && a == 16'h000A) return 16'hF000;
    return 16'h1000 + a;
  endfunction

  // Memory model: drive this cycle's response from the settled request.
  task automatic mem_drive();
    if (!mem_req || prev_fire || !prev_req) cnt = 0;
    else cnt = cnt + 1;
    mem_ack   = mem_req && (cnt >= lat);
    mem_rdata = mem_ack ? mem_word(mem_addr) : 16'h0000;
  endtask

  // One clock: consume/produce on the scoreboard, clock, check request hold.
  task automatic tick();
    logic [31:0] exp;
    logic [15:0] exp_next;
    if (redirect) begin
      sb_q.delete();
    end else if (if_valid && !stall) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra: got pc=%h instr=%h, required no valid output", if_pc, if_instr);
      end else begin
        exp      = sb_q.pop_front();
        exp_next = exp[31:16] + 16'h0002;
        pops++;
        if (if_pc !== exp[31:16] || if_instr !== exp[15:0] || if_pc_next !== exp_next) begin
          n_fail++;
          $display("FAIL sb_order: got pc=%h instr=%h next=%h, required pc=%h instr=%h next=%h",
                   if_pc, if_instr, if_pc_next, exp[31:16], exp[15:0], exp_next);
        end
      end
    end
    if (mem_req && mem_ack) begin
      if (!redirect && !drain) sb_q.push_back({mem_addr, mem_rdata});
      drain = 1'b0;
    end else if (redirect && mem_req) begin
      drain = 1'b1;
    end
    prev_req  = mem_req;
    prev_fire = mem_req && mem_ack;
    prev_addr = mem_addr;
    @(posedge clk);
    @(negedge clk);
    if (prev_req && !prev_fire) begin
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== prev_addr) begin
        n_fail++;
        $display("FAIL req_hold: got req=%b addr=%h, required req=1 addr=%h", mem_req, mem_addr, prev_addr);
      end
    end
    mem_drive();
  endtask

  task automatic apply_reset(input bit stray);
    @(negedge clk);
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    sb_q.delete(); drain = 1'b0; prev_req = 1'b0; prev_fire = 1'b0; cnt = 0;
    repeat (2) @(negedge clk);
    if (stray) begin
      mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mem_drive();
  endtask

  task automatic test_reset();
    lat = 0; hlt_en = 1'b0;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({mem_req, mem_addr, if_valid, if_instr, if_pc, if_pc_next, halted} !== {1'b0, 16'h0000, 1'b0, 48'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_vals: got req=%b addr=%h v=%b instr=%h pc=%h next=%h halted=%b, required all zero",
               mem_req, mem_addr, if_valid, if_instr, if_pc, if_pc_next, halted);
    end
    apply_reset(1'b1);
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0000 || if_valid !== 1'b0 || halted !== 1'b0) begin
      n_fail++;
      $display("FAIL first_req: got req=%b addr=%h v=%b, required req=1 addr=0000 v=0 (stray ack ignored)",
               mem_req, mem_addr, if_valid);
    end
  endtask

  task automatic test_zero_wait();
    lat = 0; apply_reset(1'b0);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (mem_req !== 1'b1 || mem_addr !== 16'(2 * i)) begin
        n_fail++;
        $display("FAIL zw_addr: got req=%b addr=%h, required req=1 addr=%h", mem_req, mem_addr, 16'(2 * i));
      end
      if (i > 0) begin
        n_checks++;
        if (if_valid !== 1'b1 || if_pc !== 16'(2 * (i - 1)) || if_instr !== 16'(16'h1000 + 2 * (i - 1))) begin
          n_fail++;
          $display("FAIL zw_out: got v=%b pc=%h instr=%h, required v=1 pc=%h instr=%h",
                   if_valid, if_pc, if_instr, 16'(2 * (i - 1)), 16'(16'h1000 + 2 * (i - 1)));
        end
      end
      tick();
    end
  endtask

  task automatic test_stall_skid();
    int k;
    lat = 3; apply_reset(1'b0);
    k = 0;
    while (!if_valid && k < 20) begin tick(); k++; end
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 16'h0000) begin
      n_fail++;
      $display("FAIL stall_first: got v=%b pc=%h, required v=1 pc=0000", if_valid, if_pc);
    end
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (if_valid !== 1'b1 || if_pc !== 16'h0000) begin
        n_fail++;
        $display("FAIL stall_hold: got v=%b pc=%h, required v=1 pc=0000", if_valid, if_pc);
      end
      tick();
    end
    n_checks++;
    if (mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL skid_full_req: got req=%b, required 0", mem_req);
    end
    stall = 1'b0; pops = 0;
    repeat (20) tick();
    n_checks++;
    if (pops < 4) begin
      n_fail++;
      $display("FAIL stall_resume: got %0d words, required at least 4", pops);
    end
  endtask

  task automatic test_back_to_back();
    lat = 0; apply_reset(1'b0);
    for (int i = 0; i < 60; i++) begin
      stall = 1'($urandom_range(0, 1));
      tick();
    end
    stall = 1'b0; pops = 0;
    repeat (6) tick();
    n_checks++;
    if (pops < 5) begin
      n_fail++;
      $display("FAIL b2b_rate: got %0d words in 6 cycles, required at least 5", pops);
    end
  endtask

  task automatic test_redirect_drain();
    int k;
    lat = 2; apply_reset(1'b0);
    k = 0;
    while (!(mem_req && mem_addr == 16'h0006) && k < 30) begin tick(); k++; end
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0006 || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_hold: got req=%b addr=%h v=%b, required req=1 addr=0006 v=0", mem_req, mem_addr, if_valid);
    end
    k = 0;
    while (mem_addr == 16'h0006 && k < 10) begin tick(); k++; end
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0040 || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_next: got req=%b addr=%h v=%b, required req=1 addr=0040 v=0", mem_req, mem_addr, if_valid);
    end
    k = 0;
    while (!if_valid && k < 10) begin tick(); k++; end
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 16'h0040 || if_instr !== 16'h1040) begin
      n_fail++;
      $display("FAIL drain_first: got v=%b pc=%h instr=%h, required v=1 pc=0040 instr=1040", if_valid, if_pc, if_instr);
    end
  endtask

  task automatic test_redirect_ack();
    int k;
    lat = 0; apply_reset(1'b0);
    k = 0;
    while (!(mem_req && mem_addr == 16'h0004) && k < 20) begin tick(); k++; end
    redirect = 1'b1; redirect_pc = 16'h0100; stall = 1'b1;
    tick();
    redirect = 1'b0; stall = 1'b0;
    n_checks++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0100 || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redir_ack: got req=%b addr=%h v=%b, required req=1 addr=0100 v=0", mem_req, mem_addr, if_valid);
    end
    tick();
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 16'h0100 || mem_addr !== 16'h0102) begin
      n_fail++;
      $display("FAIL redir_out: got v=%b pc=%h addr=%h, required v=1 pc=0100 addr=0102", if_valid, if_pc, mem_addr);
    end
  endtask

  task automatic test_wrap();
    lat = 0; apply_reset(1'b0);
    tick();
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    tick();
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 16'hFFFE || if_pc_next !== 16'h0000 || mem_addr !== 16'h0000) begin
      n_fail++;
      $display("FAIL wrap: got v=%b pc=%h next=%h addr=%h, required v=1 pc=fffe next=0000 addr=0000",
               if_valid, if_pc, if_pc_next, mem_addr);
    end
    redirect = 1'b1; redirect_pc = 16'h0011;
    tick();
    redirect = 1'b0;
    tick();
    n_checks++;
    if (if_pc !== 16'h0011 || if_pc_next !== 16'h0013 || mem_addr !== 16'h0013) begin
      n_fail++;
      $display("FAIL odd_pc: got pc=%h next=%h addr=%h, required pc=0011 next=0013 addr=0013", if_pc, if_pc_next, mem_addr);
    end
  endtask

  task automatic test_hlt();
    int k;
    lat = 0; hlt_en = 1'b1; apply_reset(1'b0);
    k = 0;
    while (!(mem_req && mem_addr == 16'h000A) && k < 20) begin tick(); k++; end
    tick();
`ifdef FETCH_HLT_DETECT_EN
    n_checks++;
    if (if_valid !== 1'b1 || if_instr !== 16'hF000 || if_pc !== 16'h000A || halted !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL hlt_enter: got v=%b instr=%h pc=%h halted=%b req=%b, required v=1 instr=f000 pc=000a halted=1 req=0",
               if_valid, if_instr, if_pc, halted, mem_req);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (mem_req !== 1'b0 || halted !== 1'b1) begin
        n_fail++;
        $display("FAIL hlt_idle: got req=%b halted=%b, required req=0 halted=1", mem_req, halted);
      end
    end
    redirect = 1'b1; redirect_pc = 16'h0000;
    tick();
    redirect = 1'b0;
    n_checks++;
    if (halted !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
      n_fail++;
      $display("FAIL hlt_exit: got halted=%b req=%b addr=%h, required halted=0 req=1 addr=0000", halted, mem_req, mem_addr);
    end
    tick();
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 16'h0000) begin
      n_fail++;
      $display("FAIL hlt_restart: got v=%b pc=%h, required v=1 pc=0000", if_valid, if_pc);
    end
`else
    n_checks++;
    if (if_instr !== 16'hF000 || if_pc !== 16'h000A || halted !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 16'h000C) begin
      n_fail++;
      $display("FAIL hlt_plain: got instr=%h pc=%h halted=%b req=%b addr=%h, required instr=f000 pc=000a halted=0 req=1 addr=000c",
               if_instr, if_pc, halted, mem_req, mem_addr);
    end
    repeat (3) tick();
`endif
    hlt_en = 1'b0;
  endtask

  task automatic test_async_reset();
    lat = 3; apply_reset(1'b0);
    tick();
    n_checks++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_wait_req: got req=%b, required 1", mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || mem_addr !== 16'h0000 || if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: got req=%b addr=%h v=%b, required req=0 addr=0000 v=0", mem_req, mem_addr, if_valid);
    end
    apply_reset(1'b0);
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall_skid();
    test_back_to_back();
    test_redirect_drain();
    test_redirect_ack();
    test_wrap();
    test_hlt();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
